tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Time-division demultiplexer: receives a serial word stream in which a 2:1/N:1 mux has interleaved
//  NUM_CH channels (slot 0 flagged by frame_sync) and steers each word to its own channel register.
//  Sits at the receive end of the TDM link, opposite the channel mux; the channel consumers sit downstream.
// PARAMETERS
//  NUM_CH  4  number of channels/slots per frame (>=2)
//  DATA_W  8  width of one channel word
// PORTS
//  clk         in   1              rising-edge clock; single clock domain
//  rst         in   1              asynchronous, active-high reset
//  in_valid    in   1              in_data/frame_sync are meaningful this cycle
//  frame_sync  in   1              qualified by in_valid: current word is slot 0
//  in_data     in   DATA_W         incoming TDM word
//  ch_data     out  NUM_CH*DATA_W  channel c word at bits [c*DATA_W +: DATA_W]
//  ch_valid    out  NUM_CH         1-cycle pulse: ch_data slice c updated
//  frame_done  out  1              1-cycle pulse: last slot (NUM_CH-1) of a frame captured
//  sync_err    out  1              1-cycle pulse: frame_sync arrived at an unexpected slot
//  locked      out  1              high while in RUN state
// BEHAVIOUR
//  Reset (async assert, sync release): state=HUNT, slot=0, ch_data=0, ch_valid=0, frame_done=0,
//   sync_err=0, locked=0. Reset mid-frame discards the partial frame; no pulses are emitted.
//  States: HUNT (no alignment), RUN (aligned, slot counter active).
//  "Beat" = cycle with in_valid=1. Cycles with in_valid=0 change nothing except clearing pulses.
//  HUNT: beat with frame_sync=0 -> dropped. Beat with frame_sync=1 -> capture as slot 0, go RUN, slot<=1.
//  RUN: each beat captures in_data into ch_data[slot], then slot<=slot+1, wrapping NUM_CH-1 -> 0.
//   The beat at slot 0 has frame_sync=1; any other beat has frame_sync=0.
//  Misalignment in RUN:
//   - frame_sync=1 at slot!=0: sync_err pulses; word captured as slot 0; slot<=1 (realign). No frame_done.
//   - frame_sync=0 at slot 0: sync_err pulses; word dropped; state<=HUNT, slot<=0.
//  Latency: ch_data slice and ch_valid[slot] are updated on the clock edge that samples the beat
//   (visible 1 cycle after the beat); all other slices hold their value. At most one ch_valid bit
//   is high in any cycle.
//  frame_done pulses in the same cycle as ch_valid[NUM_CH-1].
//  A fully aligned frame raises ch_valid[0..NUM_CH-1] in order, ends with frame_done, and never
//   raises sync_err.
//  Slot counter width = clog2(NUM_CH). The wrap is explicit (not a power-of-2 overflow), so
//   NUM_CH=3, 5, ... are correct.
//  locked = (state==RUN), registered.
//  All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared include tdm_defs.vh: state encodings ST_HUNT=1'b0 and ST_RUN=1'b1; the clog2 function.
//   The channel mux uses the same include.
//  Sub-module slot_decoder (slot index + enable -> NUM_CH one-hot): drives the capture enables and
//   the ch_valid pulses.
//  Top level: FSM, slot counter, NUM_CH x DATA_W data registers, pulse registers.
// TESTING (NUM_CH=4, DATA_W=8 unless noted)
//  1. Reset, then beats A0(sync) A1 A2 A3 with in_valid every cycle -> ch_valid pulses 0001, 0010,
//     0100, 1000 on consecutive cycles; frame_done with 1000; ch_data=A3A2A1A0; locked=1.
//  2. Same frame with in_valid low for 2 cycles between A1 and A2 -> no pulses during the gap;
//     data and order identical to scenario 1.
//  3. Locked; sync on the 3rd beat (slot 2) with data 55 -> sync_err pulse, ch_valid=0001,
//     ch_data[7:0]=55, no frame_done; the next frame is aligned with no error.
//  4. Locked; slot-0 beat without sync -> sync_err, locked=0, word dropped. Non-sync beats in HUNT
//     are ignored until the next sync.
//  5. Assert rst asynchronously mid-frame after slot 1 -> all outputs 0 immediately, HUNT; the
//     next sync frame is captured cleanly.
//  6. NUM_CH=3: two back-to-back frames -> slot wraps 2->0; frame_done twice; no sync_err.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM receive path: FSM state encoding and the
// ceiling-log2 helper used to size slot counters (also used by the channel mux).
package tdm_demux_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/tdm_demux_slot_decoder.sv
// Slot index plus enable to one-hot channel select; drives both the capture
// enables and the ch_valid pulses of the demux.
module slot_decoder #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SLOT_W = 2
) (
  input  logic [SLOT_W-1:0] slot,
  input  logic              en,
  output logic [NUM_CH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      onehot[c] = en && (slot == SLOT_W'(c));
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: aligns to frame_sync, steers each beat into its channel
// register and flags framing errors. All outputs are registered.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     frame_sync,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     frame_done,
  output logic                     sync_err,
  output logic                     locked
);

  localparam int unsigned SLOT_W = clog2(NUM_CH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

  state_t                    state_q, state_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [NUM_CH*DATA_W-1:0]  ch_data_q, ch_data_d;
  logic [NUM_CH-1:0]         ch_valid_q, ch_valid_d;
  logic                      frame_done_q, frame_done_d;
  logic                      sync_err_q, sync_err_d;
  logic                      locked_q, locked_d;

  logic                      cap_en;
  logic [SLOT_W-1:0]         cap_slot;
  logic [NUM_CH-1:0]         cap_onehot;
  logic [SLOT_W-1:0]         slot_next;

  // Explicit wrap so non-power-of-two channel counts cycle correctly.
  assign slot_next = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cap_en       = 1'b0;
    cap_slot     = slot_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (frame_sync) begin
            cap_en   = 1'b1;
            cap_slot = '0;
            state_d  = ST_RUN;
            slot_d   = SLOT_W'(1);
          end
        end
        ST_RUN: begin
          if (slot_q == '0) begin
            if (frame_sync) begin
              cap_en = 1'b1;
              slot_d = slot_next;
            end else begin
              sync_err_d = 1'b1;
              state_d    = ST_HUNT;
              slot_d     = '0;
            end
          end else if (frame_sync) begin
            sync_err_d = 1'b1;
            cap_en     = 1'b1;
            cap_slot   = '0;
            slot_d     = SLOT_W'(1);
          end else begin
            cap_en       = 1'b1;
            frame_done_d = (slot_q == LAST_SLOT);
            slot_d       = slot_next;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  slot_decoder #(
    .NUM_CH (NUM_CH),
    .SLOT_W (SLOT_W)
  ) u_slot_decoder (
    .slot   (cap_slot),
    .en     (cap_en),
    .onehot (cap_onehot)
  );

  always_comb begin
    ch_data_d  = ch_data_q;
    ch_valid_d = cap_onehot;
    locked_d   = (state_d == ST_RUN);
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (cap_onehot[c]) ch_data_d[c*DATA_W +: DATA_W] = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      slot_q       <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      locked_q     <= locked_d;
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: 4-channel instance checked cycle by cycle against a
// scoreboard fed by a behavioural model, plus a 3-channel wrap check.
module tb_tdm_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv, fs;
  logic [7:0]  d;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic        frame_done, sync_err, locked;

  logic        iv3, fs3;
  logic [7:0]  d3;
  logic [23:0] ch_data3;
  logic [2:0]  ch_valid3;
  logic        frame_done3, sync_err3, locked3;

  tdm_demux #(.NUM_CH(4), .DATA_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv), .frame_sync(fs), .in_data(d),
    .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done),
    .sync_err(sync_err), .locked(locked)
  );

  tdm_demux #(.NUM_CH(3), .DATA_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .frame_sync(fs3), .in_data(d3),
    .ch_data(ch_data3), .ch_valid(ch_valid3), .frame_done(frame_done3),
    .sync_err(sync_err3), .locked(locked3)
  );

  typedef struct packed {
    logic [3:0]  v;
    logic        fd;
    logic        se;
    logic        lk;
    logic [31:0] dat;
  } exp_t;

  exp_t sbq[$];

  int n_vec = 0;
  int n_err = 0;

  bit          m_run;
  int unsigned m_slot;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_slot = 0;
    m_data = '0;
    sbq.delete();
  endtask

  // Reference behaviour of one clock edge; the expectation is queued.
  task automatic model_step(input logic v, input logic f, input logic [7:0] dd);
    exp_t e;
    e = '0;
    if (v) begin
      if (!m_run) begin
        if (f) begin
          m_data[7:0] = dd; e.v[0] = 1'b1; m_run = 1'b1; m_slot = 1;
        end
      end else if (f) begin
        if (m_slot != 0) e.se = 1'b1;
        m_data[7:0] = dd; e.v[0] = 1'b1; m_slot = 1;
      end else if (m_slot == 0) begin
        e.se = 1'b1; m_run = 1'b0;
      end else begin
        m_data[m_slot*8 +: 8] = dd;
        e.v[m_slot] = 1'b1;
        if (m_slot == 3) e.fd = 1'b1;
        m_slot = (m_slot + 1) % 4;
      end
    end
    e.lk  = m_run;
    e.dat = m_data;
    sbq.push_back(e);
  endtask

  task automatic beat(input logic v, input logic f, input logic [7:0] dd);
    exp_t e;
    iv = v; fs = f; d = dd;
    model_step(v, f, dd);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk("ch_valid",   64'(ch_valid),   64'(e.v));
      chk("frame_done", 64'(frame_done), 64'(e.fd));
      chk("sync_err",   64'(sync_err),   64'(e.se));
      chk("locked",     64'(locked),     64'(e.lk));
      chk("ch_data",    64'(ch_data),    64'(e.dat));
    end
    iv = 1'b0;
  endtask

  task automatic frame(input logic [7:0] base);
    for (int i = 0; i < 4; i++) beat(1'b1, i == 0, base + 8'(i));
  endtask

  initial begin
    int fd_cnt;
    logic [2:0] oh;
    rst = 1'b1; iv = 1'b0; fs = 1'b0; d = '0;
    iv3 = 1'b0; fs3 = 1'b0; d3 = '0;
    model_reset();
    #1;
    chk("rst_ch_data",  64'(ch_data),  64'd0);
    chk("rst_ch_valid", 64'(ch_valid), 64'd0);
    chk("rst_locked",   64'(locked),   64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
    #1 rst = 1'b0;

    // 1: aligned frame, back-to-back beats
    frame(8'hA0);
    chk("s1_data",   64'(ch_data), 64'hA3A2A1A0);
    chk("s1_locked", 64'(locked),  64'd1);

    // 2: gap of two idle cycles mid-frame
    beat(1'b1, 1'b1, 8'hB0);
    beat(1'b1, 1'b0, 8'hB1);
    beat(1'b0, 1'b0, 8'h00);
    beat(1'b0, 1'b0, 8'h00);
    beat(1'b1, 1'b0, 8'hB2);
    beat(1'b1, 1'b0, 8'hB3);
    chk("s2_data", 64'(ch_data), 64'hB3B2B1B0);

    // 3: early sync at slot 2 realigns
    beat(1'b1, 1'b1, 8'hC0);
    beat(1'b1, 1'b0, 8'hC1);
    beat(1'b1, 1'b1, 8'h55);
    chk("s3_err",   64'(sync_err), 64'd1);
    chk("s3_valid", 64'(ch_valid), 64'h1);
    chk("s3_data",  64'(ch_data),  64'hB3B2C155);
    beat(1'b1, 1'b0, 8'hD1);
    beat(1'b1, 1'b0, 8'hD2);
    beat(1'b1, 1'b0, 8'hD3);
    frame(8'hE0);

    // 4: missing sync at slot 0 drops lock
    beat(1'b1, 1'b0, 8'hF0);
    chk("s4_err",    64'(sync_err), 64'd1);
    chk("s4_locked", 64'(locked),   64'd0);
    beat(1'b1, 1'b0, 8'hF1);
    beat(1'b1, 1'b0, 8'hF2);
    frame(8'h60);
    chk("s4_data", 64'(ch_data), 64'h63626160);

    // 5: asynchronous reset mid-frame
    beat(1'b1, 1'b1, 8'h70);
    beat(1'b1, 1'b0, 8'h71);
    #2 rst = 1'b1;
    #1;
    chk("s5_ch_data",    64'(ch_data),    64'd0);
    chk("s5_ch_valid",   64'(ch_valid),   64'd0);
    chk("s5_locked",     64'(locked),     64'd0);
    chk("s5_frame_done", 64'(frame_done), 64'd0);
    chk("s5_sync_err",   64'(sync_err),   64'd0);
    model_reset();
    #1 rst = 1'b0;
    frame(8'h80);
    chk("s5_data", 64'(ch_data), 64'h83828180);

    // 6: three-channel instance, two back-to-back frames
    fd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      iv3 = 1'b1; fs3 = (i % 3 == 0); d3 = 8'hC0 + 8'(i);
      @(posedge clk);
      #1;
      oh = 3'b001 << (i % 3);
      chk("n3_valid",      64'(ch_valid3),   64'(oh));
      chk("n3_frame_done", 64'(frame_done3), 64'(i % 3 == 2));
      chk("n3_sync_err",   64'(sync_err3),   64'd0);
      if (frame_done3) fd_cnt++;
    end
    iv3 = 1'b0;
    @(posedge clk);
    #1;
    chk("n3_idle_valid", 64'(ch_valid3), 64'd0);
    chk("n3_fd_count",   64'(fd_cnt),    64'd2);
    chk("n3_data",       64'(ch_data3),  64'hC5C4C3);
    chk("n3_locked",     64'(locked3),   64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
